alu_seq: RTL and testbench

- Command sequencer placed directly upstream of the combinational adder/multiplier ALU.
- Buffers operand/operation commands in a small FIFO using a valid/ready handshake.
- Drives the ALU operand ports from registers and captures the ALU result.
- Returns each result through a valid/ready output port, so the combinational ALU sits between two register stages under flow control.

---
 rtl/alu_seq.sv | 87 ++++++++
 tb/tb_alu_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: command FIFO and sequencer feeding a combinational ALU; results returned under valid/ready.
// Optional ALU_SEQ_CARRY_EN: a local WIDTH+1 adder drives out_carry for add commands.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_a,
    input  logic [WIDTH-1:0]              in_b,
    input  logic [7:0]                    in_op,
    output logic [WIDTH-1:0]              alu_a,
    output logic [WIDTH-1:0]              alu_b,
    output logic [7:0]                    alu_op,
    input  logic [2*WIDTH-1:0]            alu_c,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*WIDTH-1:0]            out_result,
    output logic [7:0]                    out_op,
    output logic                          out_carry,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] mem_a [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_b [FIFO_DEPTH];
    logic [7:0] mem_op [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    assign in_ready = fifo_count != (AW+1)'(FIFO_DEPTH);
    assign push = in_valid && in_ready;
    assign out_valid = state == DONE;
    // A pop is the only event that loads the operand registers and enters EXEC.
    always_comb begin
        pop = fifo_count != '0 && (state == IDLE || (state == DONE && out_ready));
        state_nx = pop ? EXEC : state == EXEC ? DONE : (state == DONE && out_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk)
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
            mem_op[wr_ptr] <= in_op;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_op <= '0;
        end else if (pop) begin
            alu_a <= mem_a[rd_ptr];
            alu_b <= mem_b[rd_ptr];
            alu_op <= mem_op[rd_ptr];
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_result <= '0;
            out_op <= '0;
        end else if (state == EXEC) begin
            out_result <= alu_c;
            out_op <= alu_op;
        end
`ifdef ALU_SEQ_CARRY_EN
    logic [WIDTH:0] sum;
    assign sum = {1'b0, alu_a} + {1'b0, alu_b};
    always_ff @(posedge clk or posedge rst)
        if (rst) out_carry <= 1'b0;
        else if (state == EXEC) out_carry <= alu_op == 8'd0 && sum[WIDTH];
`else
    assign out_carry = 1'b0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq with a behavioural add/mul ALU closing the loop.
module tb_alu_seq;
    logic clk = 0, rst = 1;
    logic in_valid = 0, in_ready, out_valid, out_ready = 0, out_carry;
    logic [7:0] in_a = 0, in_b = 0, in_op = 0, alu_a, alu_b, alu_op, out_op;
    logic [15:0] alu_c, out_result;
    logic [2:0] fifo_count;
    int checks = 0, errors = 0;
    logic exp_carry;

    always #5 clk = ~clk;

    assign alu_c = (alu_op == 8'd0) ? {8'h00, alu_a + alu_b} : 16'(alu_a) * 16'(alu_b);

    alu_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_op(out_op), .out_carry(out_carry), .fifo_count(fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        in_valid = 1; in_a = a; in_b = b; in_op = op;
        tick();
        in_valid = 0;
    endtask

    // Waits (bounded) for out_valid, checks the result, then lets one edge pass.
    task automatic expect_res(input string tag, input logic [15:0] r, input logic [7:0] op, input logic c);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_result"}, out_result, r);
        chk({tag, "_op"}, out_op, op);
        chk({tag, "_carry"}, out_carry, c);
        tick();
    endtask

    initial begin
        int accepted, nres, last, maxcnt;
`ifdef ALU_SEQ_CARRY_EN
        exp_carry = 1;
`else
        exp_carry = 0;
`endif
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        chk("rst_out", {out_result, out_op, out_carry}, 0);
        tick();
        rst = 0;
        out_ready = 1;

        // Single add: accept E0, pop E1, capture E2.
        push(200, 100, 0);
        chk("lat_e0_count", fifo_count, 1);
        chk("lat_e0_valid", out_valid, 0);
        tick();
        chk("lat_e1_valid", out_valid, 0);
        chk("lat_e1_alu", {alu_a, alu_b, alu_op}, {8'd200, 8'd100, 8'd0});
        chk("lat_e1_count", fifo_count, 0);
        tick();
        chk("lat_e2_valid", out_valid, 1);
        chk("add_result", out_result, 16'h002C);
        chk("add_op", out_op, 0);
        chk("add_carry", out_carry, exp_carry);
        tick();
        chk("add_idle", out_valid, 0);

        // Multiplies with nonzero opcodes.
        push(255, 255, 1);
        push(8'h10, 8'h10, 8'h05);
        expect_res("mul1", 16'hFE01, 1, 0);
        expect_res("mul2", 16'h0100, 5, 0);

        // Backpressure: out_ready low, push continuously.
        out_ready = 0;
        accepted = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1; in_a = 8'(k + 1); in_b = 2; in_op = 1;
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 0;
        chk("bp_accepted", accepted, 5);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_count", fifo_count, 4);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_result", out_result, 2);
        chk("bp_hold_alu_a", alu_a, 1);
        out_ready = 1;
        tick();
        chk("bp_ready_back", in_ready, 1);
        chk("bp_count_pop", fifo_count, 3);
        expect_res("bp2", 4, 1, 0);
        expect_res("bp3", 6, 1, 0);
        expect_res("bp4", 8, 1, 0);
        expect_res("bp5", 10, 1, 0);
        chk("bp_drained", {out_valid, fifo_count}, 0);

        // Throughput: one push every 2 cycles.
        nres = 0; last = -1; maxcnt = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c % 2 == 0) && c < 16;
            in_a = 8'(c / 2); in_b = 8'(c / 2); in_op = 0;
            tick();
            if (fifo_count > maxcnt) maxcnt = fifo_count;
            if (out_valid) begin
                chk("tp_result", out_result, 2 * nres);
                if (last >= 0) chk("tp_spacing", c - last, 2);
                last = c;
                nres++;
            end
        end
        in_valid = 0;
        chk("tp_count", nres, 8);
        chk("tp_maxfifo", maxcnt, 1);

        // Simultaneous push and pop at count 2.
        out_ready = 0;
        push(1, 1, 0);
        push(2, 3, 0);
        push(3, 4, 0);
        chk("pp_count_before", fifo_count, 2);
        chk("pp_first", {out_valid, out_result}, {1'b1, 16'd2});
        out_ready = 1;
        push(4, 5, 0);
        chk("pp_count_after", fifo_count, 2);
        expect_res("pp_b", 5, 0, 0);
        expect_res("pp_c", 7, 0, 0);
        expect_res("pp_d", 9, 0, 0);

        // Reset while in EXEC with 3 queued.
        out_ready = 0;
        for (int k = 0; k < 5; k++) push(8'(50 + k), 8'(50 + k), 0);
        out_ready = 1;
        tick();
        chk("mr_pre_count", fifo_count, 3);
        chk("mr_pre_valid", out_valid, 0);
        rst = 1;
        #1;
        chk("mr_async", {out_valid, in_ready, fifo_count}, {1'b0, 1'b1, 3'd0});
        tick();
        tick();
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("mr_no_stale", out_valid, 0);
        end
        push(1, 1, 0);
        expect_res("mr_fresh", 2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
